// File: rtl/selector_pkg.sv
// Shared types and helpers for the selector arbiter and related schedulers.
package selector_pkg;

  // Arbiter state encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GRANT  = 2'd2,
    GUARD  = 2'd3
  } state_t;

  // Geometry of the shared Selector_8-class decoder
  localparam int SEL_ADDR_W = 8;
  localparam int SEL_OUT_W  = 256;

  // Expected decoder output for a given address
  function automatic logic [SEL_OUT_W-1:0] onehot_of(input logic [SEL_ADDR_W-1:0] addr);
    onehot_of = '0;
    onehot_of[addr] = 1'b1;
  endfunction

endpackage

// File: rtl/selector_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward
// from ptr+1, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(N_REQ);

  // cand[gi] is the requester examined at search offset gi (gi=0 is ptr+1)
  logic [IDX_W:0]   sum_w [N_REQ];
  logic [IDX_W-1:0] cand  [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      localparam logic [IDX_W:0] OFF = (IDX_W+1)'(gi + 1);
      assign sum_w[gi] = {1'b0, ptr} + OFF;
      assign cand[gi]  = (sum_w[gi] >= N_EXT) ? IDX_W'(sum_w[gi] - N_EXT)
                                              : sum_w[gi][IDX_W-1:0];
    end
  endgenerate

  // Scan from the farthest offset down so the nearest hit wins
  always_comb begin
    pick  = '0;
    index = '0;
    any   = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        pick          = '0;
        pick[cand[k]] = 1'b1;
        index         = cand[k];
        any           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/selector_arbiter.sv
// Round-robin arbiter sharing one one-hot address selector between
// N_REQ requesters. The winner's address is latched onto the selector,
// the decoded vector is verified after a settle time, and the grant is
// held until the owner releases it.
module selector_arbiter
  import selector_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int ADDR_W         = 8,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  output logic [ADDR_W-1:0]         sel_addr,
  input  logic [(2**ADDR_W)-1:0]    decoded_in,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          ack,
  output logic [N_REQ-1:0]          nack,
  output logic                      busy,
  output logic [7:0]                fault_cnt
);

  localparam int DEC_W = 2**ADDR_W;
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state_reg;
  logic [ADDR_W-1:0]  sel_addr_reg;
  logic [N_REQ-1:0]   grant_reg;
  logic [N_REQ-1:0]   ack_reg;
  logic [N_REQ-1:0]   nack_reg;
  logic               busy_reg;
  logic [7:0]         fault_cnt_reg;
  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [IDX_W-1:0]   owner_reg;
  logic [CNT_W-1:0]   cnt_reg;

  logic [N_REQ-1:0]   pick_w;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [ADDR_W-1:0]  win_addr;
  logic [DEC_W-1:0]   exp_vec;
  logic               decode_ok;
  logic               owner_req;
  logic               settled;
  logic               timed_out;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr_reg),
    .pick  (pick_w),
    .index (pick_idx),
    .any   (pick_any)
  );

  assign win_addr = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];

  // Expected decode of the latched address; the package helper covers the
  // standard 8-bit selector, other widths fall back to a plain shift.
  generate
    if (ADDR_W == SEL_ADDR_W) begin : g_exp_std
      assign exp_vec = onehot_of(sel_addr_reg);
    end else begin : g_exp_gen
      assign exp_vec = DEC_W'(1) << sel_addr_reg;
    end
  endgenerate

  assign decode_ok = (decoded_in == exp_vec);
  assign owner_req = req[owner_reg];
  assign settled   = (cnt_reg >= SETTLE_LAST);
  assign timed_out = (cnt_reg == TIMEOUT_LAST);

  // Arbitration state machine with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      sel_addr_reg  <= '0;
      grant_reg     <= '0;
      ack_reg       <= '0;
      nack_reg      <= '0;
      busy_reg      <= 1'b0;
      fault_cnt_reg <= '0;
      rr_ptr_reg    <= IDX_W'(N_REQ - 1);
      owner_reg     <= '0;
      cnt_reg       <= '0;
    end else begin
      nack_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            sel_addr_reg <= win_addr;
            grant_reg    <= pick_w;
            rr_ptr_reg   <= pick_idx;
            owner_reg    <= pick_idx;
            cnt_reg      <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= SETTLE;
          end
        end
        SETTLE: begin
          if (!owner_req) begin
            // Owner gave up before the decode was verified: silent abort
            grant_reg <= '0;
            state_reg <= GUARD;
          end else if (settled && decode_ok) begin
            ack_reg   <= grant_reg;
            state_reg <= GRANT;
          end else if (timed_out) begin
            nack_reg  <= grant_reg;
            grant_reg <= '0;
            if (fault_cnt_reg != 8'hFF) begin
              fault_cnt_reg <= fault_cnt_reg + 8'd1;
            end
            state_reg <= GUARD;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        GRANT: begin
          // Only the owner's request matters; the decode is trusted from here
          if (!owner_req) begin
            grant_reg <= '0;
            ack_reg   <= '0;
            state_reg <= GUARD;
          end
        end
        GUARD: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign sel_addr  = sel_addr_reg;
  assign grant     = grant_reg;
  assign ack       = ack_reg;
  assign nack      = nack_reg;
  assign busy      = busy_reg;
  assign fault_cnt = fault_cnt_reg;

endmodule

// File: tb/tb_selector_arbiter.sv
// Directed bench for selector_arbiter with a Selector_8 decoder model and a
// scoreboard of expected transaction outcomes.
module tb_selector_arbiter;

  localparam int N_REQ  = 4;
  localparam int ADDR_W = 8;
  localparam int DEC_W  = 256;

  logic                    clk;
  logic                    rst;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0]       sel_addr;
  logic [DEC_W-1:0]        decoded_in;
  logic [N_REQ-1:0]        grant;
  logic [N_REQ-1:0]        ack;
  logic [N_REQ-1:0]        nack;
  logic                    busy;
  logic [7:0]              fault_cnt;
  logic                    force_zero;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [N_REQ-1:0] owner;
    bit               is_nack;
    int               latency;
  } exp_t;

  exp_t sb[$];

  selector_arbiter #(
    .N_REQ          (N_REQ),
    .ADDR_W         (ADDR_W),
    .SETTLE_CYCLES  (16),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_addr   (req_addr),
    .sel_addr   (sel_addr),
    .decoded_in (decoded_in),
    .grant      (grant),
    .ack        (ack),
    .nack       (nack),
    .busy       (busy),
    .fault_cnt  (fault_cnt)
  );

  // Selector_8 decoder model, with a stuck-at-zero fault injection
  assign decoded_in = force_zero ? '0 : (DEC_W'(1) << sel_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [7:0] a);
    req_addr[i*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic expect_result(input logic [N_REQ-1:0] owner, input bit is_nack, input int lat);
    exp_t e;
    e.owner   = owner;
    e.is_nack = is_nack;
    e.latency = lat;
    sb.push_back(e);
  endtask

  // Count cycles from grant until ack or nack shows up, then score it
  task automatic wait_result(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (ack == '0 && nack == '0 && n < 200) begin
      tick();
      n++;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_latency"}, 64'(n), 64'(e.latency));
      chk({tag, "_ack"},  64'(ack),  e.is_nack ? 64'd0 : 64'(e.owner));
      chk({tag, "_nack"}, 64'(nack), e.is_nack ? 64'(e.owner) : 64'd0);
    end
  endtask

  initial begin
    logic [N_REQ-1:0] exp_g;
    int               ptr_m;

    rst        = 1'b1;
    req        = '0;
    req_addr   = '0;
    force_zero = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_nack", 64'(nack), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fault", 64'(fault_cnt), 64'd0);
    chk("rst_sel", 64'(sel_addr), 64'd0);
    rst = 1'b0;
    tick();
    $display("txn reset done");

    // Single request
    set_addr(0, 8'h01);
    req = 4'b0001;
    expect_result(4'b0001, 1'b0, 16);
    tick();
    chk("single_grant", 64'(grant), 64'h1);
    chk("single_sel", 64'(sel_addr), 64'h1);
    chk("single_busy", 64'(busy), 64'h1);
    wait_result("single");
    tick();
    chk("single_hold_ack", 64'(ack), 64'h1);
    req = 4'b0000;
    tick();
    chk("single_rel_ack", 64'(ack), 64'h0);
    chk("single_rel_grant", 64'(grant), 64'h0);
    chk("single_guard_busy", 64'(busy), 64'h1);
    tick();
    chk("single_idle_busy", 64'(busy), 64'h0);
    $display("txn single req0 addr=01 done");

    // Round robin from reset pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_addr(i, 8'(16 + i));
    req   = 4'b1111;
    ptr_m = N_REQ - 1;
    for (int t = 0; t < 5; t++) begin
      ptr_m = (ptr_m + 1) % N_REQ;
      exp_g = 4'b0001 << ptr_m;
      expect_result(exp_g, 1'b0, 16);
      tick();
      chk("rr_grant", 64'(grant), 64'(exp_g));
      chk("rr_sel", 64'(sel_addr), 64'(16 + ptr_m));
      wait_result("rr");
      for (int h = 0; h < 5; h++) begin
        tick();
        chk("rr_onehot", 64'($onehot0(ack)), 64'd1);
        chk("rr_hold", 64'(ack), 64'(exp_g));
      end
      req[ptr_m] = 1'b0;
      tick();
      chk("rr_rel_grant", 64'(grant), 64'd0);
      req[ptr_m] = 1'b1;
      tick();
      chk("rr_guard_grant", 64'(grant), 64'd0);
      $display("txn rr owner=%0d done", ptr_m);
    end
    req = 4'b0000;
    tick();
    tick();
    tick();

    // Timeout fault
    force_zero = 1'b1;
    set_addr(2, 8'd200);
    req = 4'b0100;
    expect_result(4'b0100, 1'b1, 64);
    tick();
    chk("fault_grant", 64'(grant), 64'h4);
    chk("fault_sel", 64'(sel_addr), 64'd200);
    wait_result("fault");
    req = 4'b0000;
    chk("fault_grant_clr", 64'(grant), 64'h0);
    chk("fault_cnt", 64'(fault_cnt), 64'd1);
    tick();
    chk("fault_nack_pulse", 64'(nack), 64'h0);
    tick();
    chk("fault_idle_busy", 64'(busy), 64'h0);
    force_zero = 1'b0;
    $display("txn fault req2 addr=200 done");

    // Abort during settle
    set_addr(1, 8'd255);
    req = 4'b0010;
    tick();
    chk("abort_grant", 64'(grant), 64'h2);
    for (int k = 0; k < 5; k++) tick();
    req = 4'b0000;
    tick();
    chk("abort_grant_clr", 64'(grant), 64'h0);
    chk("abort_ack", 64'(ack), 64'h0);
    chk("abort_nack", 64'(nack), 64'h0);
    chk("abort_busy", 64'(busy), 64'h1);
    tick();
    chk("abort_idle", 64'(busy), 64'h0);
    chk("abort_fault", 64'(fault_cnt), 64'd1);
    $display("txn abort req1 addr=255 done");

    // Address stability in GRANT (pointer is at 1, so requester 0 wins)
    set_addr(0, 8'd1);
    req = 4'b0001;
    expect_result(4'b0001, 1'b0, 16);
    tick();
    chk("stab_grant", 64'(grant), 64'h1);
    wait_result("stab");
    set_addr(0, 8'd254);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stab_sel", 64'(sel_addr), 64'd1);
      chk("stab_ack", 64'(ack), 64'h1);
    end
    $display("txn stability req0 done");

    // Reset mid-GRANT, request still held
    rst = 1'b1;
    tick();
    chk("mrst_grant", 64'(grant), 64'h0);
    chk("mrst_ack", 64'(ack), 64'h0);
    chk("mrst_busy", 64'(busy), 64'h0);
    chk("mrst_sel", 64'(sel_addr), 64'h0);
    rst = 1'b0;
    tick();
    chk("mrst_regrant", 64'(grant), 64'h1);
    chk("mrst_resel", 64'(sel_addr), 64'd254);
    req = 4'b0000;
    tick();
    tick();
    $display("txn reset-mid-grant done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
